ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 120, duration the host holds the clock line low before a request.
REQ-003 Parameter START_TMO_MS, default 15, maximum wait for the device's first clock falling edge.
REQ-004 Parameter XFER_TMO_MS, default 2, maximum time from first falling edge to ack.
REQ-005 clk  in  1  system clock; the design SHALL use one clock and no other.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 tx_data  in  8  command byte to send.
REQ-008 tx_valid  in  1  request to send tx_data.
REQ-009 tx_ready  out  1  block idle; a byte is accepted on tx_valid && tx_ready.
REQ-010 ps2_clk_i  in  1  raw PS2Clk pad input (asynchronous).
REQ-011 ps2_data_i  in  1  raw PS2Data pad input (asynchronous).
REQ-012 ps2_clk_oe  out  1  1 = drive PS2Clk low, 0 = release (open-drain).
REQ-013 ps2_data_oe  out  1  1 = drive PS2Data low, 0 = release.
REQ-014 done  out  1  one-cycle pulse on a successful transfer with a device ack.
REQ-015 err_nack  out  1  one-cycle pulse when the data line is high at the 11th falling edge.
REQ-016 err_tmo  out  1  one-cycle pulse when either timeout expires.

Function
REQ-017 ps2_clk_i and ps2_data_i SHALL pass through 2-FF synchronizers; a falling edge (fe) SHALL be flagged one cycle after the synchronized clock goes 1->0.
REQ-018 States SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-019 IDLE: tx_ready=1, both oe=0; on accept, latch tx_data and parity = ~^tx_data (odd parity), then go to INHIBIT.
REQ-020 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_US*CLK_HZ/1e6 cycles; in the last cycle set ps2_data_oe=1 (start bit), then go to REQ.
REQ-021 REQ: ps2_clk_oe=0, ps2_data_oe=1; wait for fe; on fe go to SHIFT with bit index 0.
REQ-022 SHIFT: on the fe that enters SHIFT and on each subsequent fe, drive the next frame bit: data[0..7] LSB first, then parity, then stop (release); ps2_data_oe = ~bit; registered update in the cycle after fe.
REQ-023 After the stop bit has been presented, the next fe (11th overall) SHALL move to ACK handling: sampled data=0 -> WAIT_IDLE with ack ok; data=1 -> err_nack, WAIT_IDLE.
REQ-024 WAIT_IDLE: both oe=0; when synchronized clock and data are both 1, pulse done (if ack ok) and return to IDLE.
REQ-025 Start timeout: START_TMO_MS counted from the exit of INHIBIT, until the first fe.
REQ-026 Transfer timeout: XFER_TMO_MS counted from the first fe, until the ack sample.
REQ-027 Timeout expiry SHALL pulse err_tmo, release both lines on the next cycle and return to IDLE.
REQ-028 tx_valid while tx_ready=0 SHALL be ignored; no queueing.
REQ-029 done, err_nack and err_tmo SHALL be mutually exclusive and each pulse at most once per accepted byte.
REQ-030 Timer width SHALL be $clog2 of the largest cycle count; the timer saturates and does not wrap.

Reset
REQ-031 On rst: state IDLE; tx_ready=1; ps2_clk_oe=0; ps2_data_oe=0; done, err_nack and err_tmo = 0; counters, synchronizers and the latched byte cleared (synchronizers cleared to 1).
REQ-032 rst asserted mid-transfer SHALL release both lines in the cycle after rst is sampled, with no status pulse.

Structure
REQ-033 Package ps2_pkg SHALL hold the state enum, the frame length (11) and the INHIBIT/timeout cycle-count functions.
REQ-034 Sub-module ps2_sync_fe SHALL hold the 2-FF synchronizer and fe detector; it is reused by the receive path.
REQ-035 The top level SHALL implement the pad tri-states (pad = oe ? 0 : Z) outside this block.

Verification
REQ-036 Send 0xF4 with a device model at 12.5 kHz -> ps2_clk_oe high 12000 cycles; data bits 0,0,1,0,1,1,1,1, parity 0, stop released; device acks -> done pulse; tx_ready returns to 1.
REQ-037 Send 0xFF -> parity bit 1; send 0x00 -> parity bit 1; both acked -> done.
REQ-038 Device never clocks -> err_tmo exactly 1_500_000 cycles after INHIBIT ends; both oe=0; no done.
REQ-039 Device clocks all 11 edges but holds data high at the ack -> err_nack, then IDLE once the lines are high.
REQ-040 rst asserted at the 5th fe -> both oe=0 and tx_ready=1 the next cycle; the next send of 0xF4 completes normally.
REQ-041 tx_valid pulsed with 0xAA during SHIFT -> ignored; the frame of the original byte is unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmit path.
// Cycle counts are derived from the system clock so timing holds at any CLK_HZ.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  // Start + 8 data + parity + stop, with the ack sampled on the edge after stop.
  localparam int FRAME_LEN = 11;

  function automatic int unsigned inhibit_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned us);
    return 32'((clk_hz * us) / 64'd1_000_000);
  endfunction

  function automatic int unsigned tmo_cycles(input longint unsigned clk_hz,
                                             input longint unsigned ms);
    return 32'((clk_hz * ms) / 64'd1_000);
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_fe.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a registered
// falling-edge flag on the synchronized clock.
module ps2_sync_fe
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync,
  output logic data_sync,
  output logic fe
);

  logic clk_meta_r, clk_sync_r, clk_prev_r;
  logic data_meta_r, data_sync_r;
  logic fe_r;

  // Synchronizer chains idle high, matching released open-drain lines
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      fe_r        <= 1'b0;
    end else begin
      clk_meta_r  <= ps2_clk_i;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_i;
      data_sync_r <= data_meta_r;
      fe_r        <= clk_prev_r & ~clk_sync_r;
    end
  end

  assign clk_sync  = clk_sync_r;
  assign data_sync = data_sync_r;
  assign fe        = fe_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to send,
// shifts out one byte on device-generated clock edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 32'd100_000_000,
  parameter int unsigned INHIBIT_US   = 32'd120,
  parameter int unsigned START_TMO_MS = 32'd15,
  parameter int unsigned XFER_TMO_MS  = 32'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err_nack,
  output logic       err_tmo
);

  localparam int unsigned INH_CYC   = inhibit_cycles(64'(CLK_HZ), 64'(INHIBIT_US));
  localparam int unsigned START_CYC = tmo_cycles(64'(CLK_HZ), 64'(START_TMO_MS));
  localparam int unsigned XFER_CYC  = tmo_cycles(64'(CLK_HZ), 64'(XFER_TMO_MS));
  localparam int unsigned MAX_CYC   = (INH_CYC > START_CYC)
                                    ? ((INH_CYC > XFER_CYC) ? INH_CYC : XFER_CYC)
                                    : ((START_CYC > XFER_CYC) ? START_CYC : XFER_CYC);
  localparam int TMR_W = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INH_CYC - 32'd1);
  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_CYC - 32'd1);
  localparam logic [TMR_W-1:0] XFER_LAST  = TMR_W'(XFER_CYC - 32'd1);
  localparam logic [3:0]       STOP_IDX   = 4'(FRAME_LEN - 2);

  ps2_state_e             state_r, state_next_s;
  logic [TMR_W-1:0]       timer_r, timer_next_s, timer_inc_s;
  logic [3:0]             bit_idx_r, bit_idx_next_s;
  logic [FRAME_LEN-2:0]   frame_r, frame_next_s;
  logic                   ack_ok_r, ack_ok_next_s;
  logic                   tx_ready_r, clk_oe_r, data_oe_r, done_r, nack_r, tmo_r;
  logic                   clk_oe_next_s, data_oe_next_s, done_next_s, nack_next_s, tmo_next_s;
  logic                   clk_sync_s, data_sync_s, fe_s;

  ps2_sync_fe u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_sync   (clk_sync_s),
    .data_sync  (data_sync_s),
    .fe         (fe_s)
  );

  // Saturating increment keeps a stalled timer from wrapping back into range
  assign timer_inc_s = (timer_r == {TMR_W{1'b1}}) ? timer_r : timer_r + TMR_W'(1);

  // Next-state, timer and pad-drive decisions
  always_comb begin
    state_next_s   = state_r;
    timer_next_s   = timer_inc_s;
    bit_idx_next_s = bit_idx_r;
    frame_next_s   = frame_r;
    ack_ok_next_s  = ack_ok_r;
    clk_oe_next_s  = 1'b0;
    data_oe_next_s = 1'b0;
    done_next_s    = 1'b0;
    nack_next_s    = 1'b0;
    tmo_next_s     = 1'b0;
    case (state_r)
      IDLE: begin
        timer_next_s = {TMR_W{1'b0}};
        if (tx_valid && tx_ready_r) begin
          frame_next_s   = {1'b1, odd_parity(tx_data), tx_data};
          ack_ok_next_s  = 1'b0;
          state_next_s   = INHIBIT;
          clk_oe_next_s  = 1'b1;
          data_oe_next_s = (INH_LAST == {TMR_W{1'b0}});
        end else begin
          state_next_s = IDLE;
        end
      end
      INHIBIT: begin
        if (timer_r == INH_LAST) begin
          state_next_s   = REQ;
          timer_next_s   = {TMR_W{1'b0}};
          data_oe_next_s = 1'b1;
        end else begin
          clk_oe_next_s  = 1'b1;
          // Start bit goes out during the final inhibit cycle
          data_oe_next_s = (timer_inc_s == INH_LAST);
        end
      end
      REQ: begin
        data_oe_next_s = 1'b1;
        if (fe_s) begin
          state_next_s   = SHIFT;
          timer_next_s   = {TMR_W{1'b0}};
          bit_idx_next_s = 4'd1;
          data_oe_next_s = ~frame_r[0];
        end else if (timer_r == START_LAST) begin
          state_next_s   = IDLE;
          tmo_next_s     = 1'b1;
          data_oe_next_s = 1'b0;
        end else begin
          state_next_s = REQ;
        end
      end
      SHIFT: begin
        data_oe_next_s = data_oe_r;
        if (fe_s) begin
          data_oe_next_s = ~frame_r[bit_idx_r];
          bit_idx_next_s = bit_idx_r + 4'd1;
          if (bit_idx_r == STOP_IDX) begin
            state_next_s = ACK;
          end else begin
            state_next_s = SHIFT;
          end
        end else if (timer_r == XFER_LAST) begin
          state_next_s   = IDLE;
          tmo_next_s     = 1'b1;
          data_oe_next_s = 1'b0;
        end else begin
          state_next_s = SHIFT;
        end
      end
      ACK: begin
        if (fe_s) begin
          state_next_s  = WAIT_IDLE;
          ack_ok_next_s = ~data_sync_s;
          nack_next_s   = data_sync_s;
        end else if (timer_r == XFER_LAST) begin
          state_next_s = IDLE;
          tmo_next_s   = 1'b1;
        end else begin
          state_next_s = ACK;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync_s && data_sync_s) begin
          state_next_s = IDLE;
          done_next_s  = ack_ok_r;
        end else begin
          state_next_s = WAIT_IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      timer_r    <= {TMR_W{1'b0}};
      bit_idx_r  <= 4'd0;
      frame_r    <= {(FRAME_LEN-1){1'b0}};
      ack_ok_r   <= 1'b0;
      tx_ready_r <= 1'b1;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      done_r     <= 1'b0;
      nack_r     <= 1'b0;
      tmo_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      timer_r    <= timer_next_s;
      bit_idx_r  <= bit_idx_next_s;
      frame_r    <= frame_next_s;
      ack_ok_r   <= ack_ok_next_s;
      tx_ready_r <= (state_next_s == IDLE);
      clk_oe_r   <= clk_oe_next_s;
      data_oe_r  <= data_oe_next_s;
      done_r     <= done_next_s;
      nack_r     <= nack_next_s;
      tmo_r      <= tmo_next_s;
    end
  end

  assign tx_ready    = tx_ready_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign done        = done_r;
  assign err_nack    = nack_r;
  assign err_tmo     = tmo_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of
// the host at 12.5 kHz (1 MHz system clock) and checks frames, acks and timeouts.
module tb_ps2_host_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int INH    = 120 * CLK_HZ / 1_000_000;
  localparam int START  = 15 * CLK_HZ / 1_000;
  localparam int HALF   = CLK_HZ / 12_500 / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, err_nack, err_tmo;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  wire logic  clk_line  = ~ps2_clk_oe & dev_clk;
  wire logic  data_line = ~ps2_data_oe & dev_data;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int nack_cnt = 0;
  int tmo_cnt = 0;

  ps2_host_tx #(
    .CLK_HZ       (32'd1_000_000),
    .INHIBIT_US   (32'd120),
    .START_TMO_MS (32'd15),
    .XFER_TMO_MS  (32'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (clk_line),
    .ps2_data_i  (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .err_nack    (err_nack),
    .err_tmo     (err_tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)     done_cnt <= done_cnt + 1;
    if (err_nack) nack_cnt <= nack_cnt + 1;
    if (err_tmo)  tmo_cnt  <= tmo_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept a byte, then measure the inhibit window; leaves us at the first REQ cycle
  task automatic request(input logic [7:0] b);
    int n, d_hi, last_d;
    n = 0; d_hi = 0; last_d = 0;
    @(negedge clk);
    check("ready_before", {31'd0, tx_ready}, 32'd1);
    tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h5A;
    while (ps2_clk_oe === 1'b1 && n < 4 * INH) begin
      n++;
      d_hi += int'(ps2_data_oe);
      last_d = int'(ps2_data_oe);
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("start_oe_cycles", d_hi, 1);
    check("start_oe_last", last_d, 1);
    check("start_bit_line", {31'd0, data_line}, 32'd0);
  endtask

  // Full transfer with the device model; rst_fe>0 aborts by reset after that edge
  task automatic send(input logic [7:0] b, input bit ack, input int rst_fe, input bit inject);
    logic [9:0] got, exp;
    int d0, n0, t0, w, k;
    bit aborted;
    got = 10'd0; aborted = 1'b0; k = 1;
    exp = {1'b1, ($countones(b) % 2 == 0) ? 1'b1 : 1'b0, b};
    d0 = done_cnt; n0 = nack_cnt; t0 = tmo_cnt;
    request(b);
    repeat (20) @(negedge clk);
    while (k <= 11 && !aborted) begin
      dev_clk = 1'b0;
      if (k == rst_fe) begin
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        dev_clk = 1'b1;
        aborted = 1'b1;
      end else begin
        if (inject && k == 3) begin
          repeat (6) @(negedge clk);
          check("busy_ready", {31'd0, tx_ready}, 32'd0);
          tx_data = 8'hAA; tx_valid = 1'b1;
          @(negedge clk);
          tx_valid = 1'b0;
          repeat (HALF - 7) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
        if (k <= 10) got[k-1] = data_line;
        dev_clk = 1'b1;
        if (k == 10 && ack) dev_data = 1'b0;
        repeat (HALF) @(negedge clk);
        k++;
      end
    end
    dev_data = 1'b1;
    if (aborted) begin
      repeat (50) @(negedge clk);
      check("rst_no_pulse", done_cnt + nack_cnt + tmo_cnt, d0 + n0 + t0);
      check("rst_idle_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    end else begin
      w = 0;
      while (tx_ready !== 1'b1 && w < 500) begin
        w++;
        @(negedge clk);
      end
      check("ready_timeout", {31'd0, tx_ready}, 32'd1);
      repeat (3) @(negedge clk);
      check("frame_bits", {22'd0, got}, {22'd0, exp});
      check("done_pulses", done_cnt - d0, ack ? 1 : 0);
      check("nack_pulses", nack_cnt - n0, ack ? 0 : 1);
      check("tmo_pulses", tmo_cnt - t0, 0);
      check("idle_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    end
  endtask

  initial begin
    int n, d0, t0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", {31'd0, tx_ready}, 32'd1);
    check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("reset_pulses", {29'd0, done, err_nack, err_tmo}, 32'd0);

    send(8'hF4, 1'b1, 0, 1'b0);
    send(8'hFF, 1'b1, 0, 1'b0);
    send(8'h00, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0);

    send(8'h3C, 1'b0, 0, 1'b0);
    send(8'hF4, 1'b1, 5, 1'b0);
    send(8'hF4, 1'b1, 0, 1'b0);
    send(8'h5B, 1'b1, 0, 1'b1);

    // Device never clocks: start timeout counted from the first REQ cycle
    d0 = done_cnt; t0 = tmo_cnt; n = 0;
    request(8'hED);
    while (err_tmo !== 1'b1 && n < START + 100) begin
      n++;
      @(negedge clk);
    end
    check("start_tmo_cycles", n, START);
    check("tmo_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("tmo_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check("tmo_one_cycle", {31'd0, err_tmo}, 32'd0);
    repeat (3) @(negedge clk);
    check("tmo_count", tmo_cnt - t0, 1);
    check("tmo_no_done", done_cnt - d0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
